// File: rtl/imem_uart_loader.sv
// imem_uart_loader: receives an 8N1 UART stream framed as LEN, LEN bytes,
// CSUM and writes the bytes into instruction memory from address 0,
// holding the CPU in reset while the load is in progress.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    L_LEN  = 3'd0,
    L_DATA = 3'd1,
    L_CSUM = 3'd2,
    L_DONE = 3'd3,
    L_ERR  = 3'd4
  } ld_state_t;

  // Synchronizer flops, preset to the idle line level.
  logic rx_meta_r;
  logic rx_s_r;

  // Receiver state.
  rx_state_t   rx_state_r;
  logic [TW-1:0] timer_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic        stop_wait_r;
  logic        byte_valid_r;
  logic [7:0]  byte_data_r;
  logic        frame_err_r;

  // Loader state.
  ld_state_t         ld_state_r;
  logic [ADDR_W-1:0] remaining_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        sum_r;

  // Bring the asynchronous rx line into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
    end
  end

  // UART receive FSM: start-bit qualification, 8 data bits LSB first, stop check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_r   <= R_IDLE;
      timer_r      <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      stop_wait_r  <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        R_IDLE: begin
          stop_wait_r <= 1'b0;
          if (!rx_s_r) begin
            rx_state_r <= R_START;
            timer_r    <= '0;
          end else begin
            rx_state_r <= R_IDLE;
          end
        end
        R_START: begin
          if (timer_r == T_HALF) begin
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            if (rx_s_r) begin
              rx_state_r <= R_IDLE;   // glitch, not a real start bit
            end else begin
              rx_state_r <= R_DATA;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        R_DATA: begin
          if (timer_r == T_FULL) begin
            timer_r   <= '0;
            shift_r   <= {rx_s_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              rx_state_r <= R_STOP;
            end else begin
              rx_state_r <= R_DATA;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        R_STOP: begin
          if (stop_wait_r) begin
            // Framing error already reported; wait for the line to idle.
            if (rx_s_r) begin
              rx_state_r  <= R_IDLE;
              stop_wait_r <= 1'b0;
            end else begin
              rx_state_r <= R_STOP;
            end
          end else if (timer_r == T_FULL) begin
            timer_r <= '0;
            if (rx_s_r) begin
              byte_valid_r <= 1'b1;
              byte_data_r  <= shift_r;
              rx_state_r   <= R_IDLE;
            end else begin
              frame_err_r <= 1'b1;
              stop_wait_r <= 1'b1;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          rx_state_r  <= R_IDLE;
          timer_r     <= '0;
          stop_wait_r <= 1'b0;
        end
      endcase
    end
  end

  // Loader FSM: parse LEN/data/CSUM, issue IMEM writes and drive status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state_r  <= L_LEN;
      remaining_r <= '0;
      addr_r      <= '0;
      sum_r       <= 8'h00;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 8'h00;
      cpu_hold    <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (ld_state_r)
        L_LEN, L_DONE, L_ERR: begin
          // Idle, finished and failed all wait for a nonzero LEN to restart.
          if (byte_valid_r && (byte_data_r != 8'h00)) begin
            remaining_r <= ADDR_W'(byte_data_r);
            addr_r      <= '0;
            sum_r       <= 8'h00;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            cpu_hold    <= 1'b1;
            ld_state_r  <= L_DATA;
          end else begin
            ld_state_r <= ld_state_r;
          end
        end
        L_DATA: begin
          if (frame_err_r) begin
            load_error <= 1'b1;
            cpu_hold   <= 1'b1;
            ld_state_r <= L_ERR;
          end else if (byte_valid_r) begin
            imem_we     <= 1'b1;
            imem_addr   <= addr_r;
            imem_wdata  <= byte_data_r;
            addr_r      <= addr_r + ADDR_W'(1);
            sum_r       <= sum_r + byte_data_r;
            remaining_r <= remaining_r - ADDR_W'(1);
            if (remaining_r == ADDR_W'(1)) begin
              ld_state_r <= L_CSUM;
            end else begin
              ld_state_r <= L_DATA;
            end
          end else begin
            ld_state_r <= L_DATA;
          end
        end
        L_CSUM: begin
          if (frame_err_r) begin
            load_error <= 1'b1;
            cpu_hold   <= 1'b1;
            ld_state_r <= L_ERR;
          end else if (byte_valid_r) begin
            if (byte_data_r == sum_r) begin
              load_done  <= 1'b1;
              cpu_hold   <= 1'b0;
              ld_state_r <= L_DONE;
            end else begin
              load_error <= 1'b1;
              cpu_hold   <= 1'b1;
              ld_state_r <= L_ERR;
            end
          end else begin
            ld_state_r <= L_CSUM;
          end
        end
        default: begin
          ld_state_r <= L_LEN;
        end
      endcase
    end
  end

endmodule
